// File: rtl/cpc_ram_pkg.sv
// Shared types and constants for the CPC RAM-bank select master.
package cpc_ram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3,
        ST_REL
    } bank_sel_state_t;

    localparam logic [15:0] BANK_SEL_PORT   = 16'h7FFF;
    localparam logic [1:0]  BANK_SEL_PREFIX = 2'b11;
    localparam int          RAMBLK_W        = 8;
    localparam int          BANK_IDX_W      = 3;

    // Build the byte written to the select port from a cccbbb value.
    function automatic logic [RAMBLK_W-1:0] bank_sel_byte(input logic [2*BANK_IDX_W-1:0] cccbbb);
        return {BANK_SEL_PREFIX, cccbbb};
    endfunction

endpackage

// File: rtl/cpc_bank_sel_master_if.sv
// Z80-style expansion bus as seen by the bank-select master and by a card.
interface cpc_bank_sel_master_if
    import cpc_ram_pkg::*;
;
    logic                busreq_b;
    logic                busack_b;
    logic                bus_oe;
    logic [15:0]         adr;
    logic [RAMBLK_W-1:0] data;
    logic                iorq_b;
    logic                wr_b;
    logic                rd_b;
    logic                mreq_b;
    logic                ready;

    modport master (
        output busreq_b, bus_oe, adr, data, iorq_b, wr_b, rd_b, mreq_b,
        input  busack_b, ready
    );

    modport slave (
        input  busreq_b, bus_oe, adr, data, iorq_b, wr_b, rd_b, mreq_b,
        output busack_b, ready
    );

endinterface

// File: rtl/cpc_iowr_timer.sv
// 4-bit loadable down-counter; load wins over decrement, decrement wraps.
module cpc_iowr_timer (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       load_i,
    input  logic [3:0] val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q, cnt_d;

    // Next count: load a new value, or step down by one.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)     cnt_d = val_i;
        else if (dec_i) cnt_d = cnt_q - 4'd1;
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/cpc_bank_sel_master.sv
// Bus master issuing one I/O write to the RAM-bank select port per command:
// BUSREQ/BUSACK, T1-T2-TW-T3, release. Optional CPC_READY_WAIT_EN stretches
// the final wait state on a low ready input, up to 15 extra cycles.
module cpc_bank_sel_master
    import cpc_ram_pkg::*;
#(
    parameter logic [15:0] PORT_ADR    = BANK_SEL_PORT,
    parameter int          NUM_TW      = 1,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset_b,
    input  logic                      cmd_valid,
    input  logic [2*BANK_IDX_W-1:0]   cmd_bank,
    output logic                      cmd_ready,
    output logic                      done,
    output logic                      err,
    output logic [RAMBLK_W-1:0]       last_bank,
    cpc_bank_sel_master_if.master     bus
);

    if (NUM_TW < 1 || NUM_TW > 3) begin : g_bad_num_tw
        $error("cpc_bank_sel_master: NUM_TW must be in 1..3");
    end
    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
        $error("cpc_bank_sel_master: ACK_TIMEOUT must be in 1..255");
    end
    if (PORT_ADR[15] != 1'b0) begin : g_bad_port
        $error("cpc_bank_sel_master: PORT_ADR bit 15 must be 0");
    end

    // Timeout is preloaded with ACK_TIMEOUT-1 so REQ lasts exactly ACK_TIMEOUT cycles.
    localparam logic [7:0] TO_LOAD = 8'(ACK_TIMEOUT - 1);
    localparam logic [3:0] TW_LOAD = 4'(NUM_TW - 1);

    bank_sel_state_t     state_q;
    logic [RAMBLK_W-1:0] data_q, dout_q, last_bank_q;
    logic [15:0]         adr_q;
    logic                bus_oe_q, strb_b_q, busreq_b_q;
    logic                cmd_ready_q, done_q, err_q;
`ifdef CPC_READY_WAIT_EN
    logic                rdy_err_q;
`else
    logic                unused_ready;
    assign unused_ready = bus.ready;
`endif

    // Timer [0]: low nibble of the ack timeout, then the TW count.
    // Timer [1]: high nibble of the ack timeout, then the ready extension.
    logic [1:0]      tmr_load, tmr_dec, tmr_zero;
    logic [1:0][3:0] tmr_val;
    logic            accept, to_hit;

    assign accept = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
    assign to_hit = tmr_zero[0] & tmr_zero[1];

    cpc_iowr_timer u_tmr [1:0] (
        .clk     (clk),
        .reset_b (reset_b),
        .load_i  (tmr_load),
        .val_i   (tmr_val),
        .dec_i   (tmr_dec),
        .zero_o  (tmr_zero)
    );

    // Timer control: cascaded 8-bit countdown in REQ, wait/extension count in TW.
    always_comb begin
        tmr_load = '0;
        tmr_val  = '0;
        tmr_dec  = '0;
        case (state_q)
            ST_IDLE: if (accept) begin
                tmr_load = 2'b11;
                tmr_val  = TO_LOAD;
            end
            ST_REQ: if (bus.busack_b && !to_hit) begin
                tmr_dec[0] = 1'b1;
                tmr_dec[1] = tmr_zero[0];
            end
            ST_T1: begin
                tmr_load   = 2'b11;
                tmr_val[0] = TW_LOAD;
                tmr_val[1] = 4'd15;
            end
            ST_TW: begin
                if (!tmr_zero[0]) tmr_dec[0] = 1'b1;
`ifdef CPC_READY_WAIT_EN
                else if (!bus.ready && !tmr_zero[1]) tmr_dec[1] = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Cycle sequencer with registered bus and status outputs.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            dout_q      <= '0;
            adr_q       <= '0;
            last_bank_q <= '0;
            bus_oe_q    <= 1'b0;
            strb_b_q    <= 1'b1;
            busreq_b_q  <= 1'b1;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef CPC_READY_WAIT_EN
            rdy_err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_q      <= bank_sel_byte(cmd_bank);
                        busreq_b_q  <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_REQ;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!bus.busack_b) begin
                        bus_oe_q <= 1'b1;
                        adr_q    <= PORT_ADR;
                        dout_q   <= data_q;
                        state_q  <= ST_T1;
                    end else if (to_hit) begin
                        busreq_b_q <= 1'b1;
                        err_q      <= 1'b1;
                        state_q    <= ST_REL;
                    end
                end
                ST_T1: begin
                    strb_b_q  <= 1'b0;
`ifdef CPC_READY_WAIT_EN
                    rdy_err_q <= 1'b0;
`endif
                    state_q   <= ST_T2;
                end
                ST_T2: state_q <= ST_TW;
                ST_TW: begin
                    if (tmr_zero[0]) begin
`ifdef CPC_READY_WAIT_EN
                        if (bus.ready) begin
                            state_q <= ST_T3;
                        end else if (tmr_zero[1]) begin
                            rdy_err_q <= 1'b1;
                            state_q   <= ST_T3;
                        end
`else
                        state_q <= ST_T3;
`endif
                    end
                end
                ST_T3: begin
                    strb_b_q    <= 1'b1;
                    bus_oe_q    <= 1'b0;
                    busreq_b_q  <= 1'b1;
                    last_bank_q <= dout_q;
                    done_q      <= 1'b1;
`ifdef CPC_READY_WAIT_EN
                    err_q       <= rdy_err_q;
`endif
                    state_q     <= ST_REL;
                end
                ST_REL: begin
                    // adr/data are held here so they outlast the strobe negation.
                    if (bus.busack_b) begin
                        adr_q       <= '0;
                        dout_q      <= '0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign done         = done_q;
    assign err          = err_q;
    assign last_bank    = last_bank_q;
    assign bus.busreq_b = busreq_b_q;
    assign bus.bus_oe   = bus_oe_q;
    assign bus.adr      = adr_q;
    assign bus.data     = dout_q;
    assign bus.iorq_b   = strb_b_q;
    assign bus.wr_b     = strb_b_q;
    assign bus.rd_b     = 1'b1;
    assign bus.mreq_b   = 1'b1;

endmodule
